// File: rtl/morse_pkg.sv
// morse_pkg: shared FSM encoding and constants for the Morse decoder.
package morse_pkg;
   typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
   localparam int MAX_SYMBOLS = 5;
   localparam int BUF_DEPTH = 5;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
endpackage

// File: rtl/morse_lut.sv
// morse_lut: combinational Morse pattern to ASCII lookup (bit 0 = first symbol, 1 = dash).
module morse_lut
   import morse_pkg::*;
(
   input  logic [2:0] len,
   input  logic [4:0] pattern,
   input  logic       overflow,
   output logic [7:0] ascii
);
   always_comb begin
      ascii = ASCII_UNKNOWN;
      if (!overflow)
         case ({len, pattern})
            {3'd2, 5'b00010}: ascii = "A";
            {3'd4, 5'b00001}: ascii = "B";
            {3'd4, 5'b00101}: ascii = "C";
            {3'd3, 5'b00001}: ascii = "D";
            {3'd1, 5'b00000}: ascii = "E";
            {3'd4, 5'b00100}: ascii = "F";
            {3'd3, 5'b00011}: ascii = "G";
            {3'd4, 5'b00000}: ascii = "H";
            {3'd2, 5'b00000}: ascii = "I";
            {3'd4, 5'b01110}: ascii = "J";
            {3'd3, 5'b00101}: ascii = "K";
            {3'd4, 5'b00010}: ascii = "L";
            {3'd2, 5'b00011}: ascii = "M";
            {3'd2, 5'b00001}: ascii = "N";
            {3'd3, 5'b00111}: ascii = "O";
            {3'd4, 5'b00110}: ascii = "P";
            {3'd4, 5'b01011}: ascii = "Q";
            {3'd3, 5'b00010}: ascii = "R";
            {3'd3, 5'b00000}: ascii = "S";
            {3'd1, 5'b00001}: ascii = "T";
            {3'd3, 5'b00100}: ascii = "U";
            {3'd4, 5'b01000}: ascii = "V";
            {3'd3, 5'b00110}: ascii = "W";
            {3'd4, 5'b01001}: ascii = "X";
            {3'd4, 5'b01101}: ascii = "Y";
            {3'd4, 5'b00011}: ascii = "Z";
            {3'd5, 5'b11111}: ascii = "0";
            {3'd5, 5'b11110}: ascii = "1";
            {3'd5, 5'b11100}: ascii = "2";
            {3'd5, 5'b11000}: ascii = "3";
            {3'd5, 5'b10000}: ascii = "4";
            {3'd5, 5'b00000}: ascii = "5";
            {3'd5, 5'b00001}: ascii = "6";
            {3'd5, 5'b00011}: ascii = "7";
            {3'd5, 5'b00111}: ascii = "8";
            {3'd5, 5'b01111}: ascii = "9";
            default:          ascii = ASCII_UNKNOWN;
         endcase
   end
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: debounced Morse key to ASCII with a five-character scrolling text buffer.
module morse_decoder
   import morse_pkg::*;
#(
   parameter int UNIT = 12500000,
   parameter int DEBOUNCE = 250000
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        iKey,
   input  logic        iClear,
   output logic [7:0]  oChar,
   output logic        oValid,
   output logic [39:0] oTextBuf,
   output logic [2:0]  oCount
);
   localparam int CW = $clog2(3 * UNIT + 1);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] DASH_MIN = CW'(2 * UNIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(3 * UNIT);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
   logic [1:0] sync;
   logic key_db, key_dly, rise, fall, ovf, ovf_n, decode;
   logic [DW-1:0] db_cnt;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] len, len_n;
   logic [4:0] pat, pat_n;
   logic [7:0] ascii;
   logic [7:0] text [BUF_DEPTH];
   state_t state, state_n;
   assign rise = key_db & ~key_dly;
   assign fall = ~key_db & key_dly;
   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         sync <= '0;
         key_db <= 1'b0;
         key_dly <= 1'b0;
         db_cnt <= '0;
      end else begin
         sync <= {sync[0], iKey};
         key_dly <= key_db;
         if (sync[1] == key_db) db_cnt <= '0;
         else if (db_cnt == DEB_LAST) begin
            key_db <= sync[1];
            db_cnt <= '0;
         end else db_cnt <= db_cnt + 1'b1;
      end
   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         state <= IDLE;
         cnt <= '0;
         len <= '0;
         pat <= '0;
         ovf <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         len <= len_n;
         pat <= pat_n;
         ovf <= ovf_n;
      end
   always_comb begin
      state_n = state;
      cnt_n = (state == IDLE || cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      len_n = len;
      pat_n = pat;
      ovf_n = ovf;
      decode = 1'b0;
      if (iClear) begin
         state_n = IDLE;
         cnt_n = '0;
         len_n = '0;
         pat_n = '0;
         ovf_n = 1'b0;
      end else if (state == PRESS) begin
         if (fall) begin
            state_n = GAP;
            cnt_n = '0;
            if (len == 3'(MAX_SYMBOLS)) ovf_n = 1'b1;
            else begin
               len_n = len + 1'b1;
               pat_n[len] = cnt >= DASH_MIN;
            end
         end
      end else if (state == GAP && cnt == CNT_MAX) begin
         // a press landing on the decode cycle starts the next letter
         decode = 1'b1;
         state_n = rise ? PRESS : IDLE;
         cnt_n = '0;
         len_n = '0;
         pat_n = '0;
         ovf_n = 1'b0;
      end else if (rise) begin
         state_n = PRESS;
         cnt_n = '0;
      end
   end
   morse_lut u_lut (
      .len(len),
      .pattern(pat),
      .overflow(ovf),
      .ascii(ascii)
   );
   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         text <= '{default: ASCII_SPACE};
         oCount <= '0;
         oChar <= ASCII_SPACE;
         oValid <= 1'b0;
      end else begin
         oValid <= decode;
         if (iClear) begin
            text <= '{default: ASCII_SPACE};
            oCount <= '0;
         end else if (decode) begin
            oChar <= ascii;
            if (oCount == 3'(BUF_DEPTH)) begin
               for (int j = 0; j < BUF_DEPTH - 1; j++) text[j] <= text[j+1];
               text[BUF_DEPTH-1] <= ascii;
            end else begin
               text[oCount] <= ascii;
               oCount <= oCount + 1'b1;
            end
         end
      end
   for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_out
      assign oTextBuf[8*i +: 8] = text[i];
   end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed self-checking bench for morse_decoder with UNIT=10, DEBOUNCE=2.
module tb_morse_decoder;
   logic clk = 1'b0;
   logic rst_n, key, clear;
   logic [7:0] o_char;
   logic o_valid;
   logic [39:0] o_buf;
   logic [2:0] o_count;
   int checks = 0;
   int failures = 0;
   int vcnt = 0;
   int vbase;
   localparam logic [39:0] SPACES = {5{8'h20}};
   morse_decoder #(.UNIT(10), .DEBOUNCE(2)) dut (
      .iCLK(clk),
      .iRST_n(rst_n),
      .iKey(key),
      .iClear(clear),
      .oChar(o_char),
      .oValid(o_valid),
      .oTextBuf(o_buf),
      .oCount(o_count)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (o_valid) vcnt++;
   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic press(input int n);
      key = 1'b1;
      tick(n);
      key = 1'b0;
   endtask
   task automatic send(input string code);
      for (int i = 0; i < code.len(); i++) begin
         press(code[i] == "-" ? 30 : 10);
         tick(10);
      end
      tick(30);
   endtask
   task automatic do_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_char"}, 40'(o_char), 40'h20);
      chk({tag, "_valid"}, 40'(o_valid), 40'h0);
      chk({tag, "_buf"}, o_buf, SPACES);
      chk({tag, "_count"}, 40'(o_count), 40'h0);
   endtask
   initial begin
      rst_n = 1'b0;
      key = 1'b0;
      clear = 1'b0;
      tick(3);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick(5);
      chk_reset_outputs("idle");
      // letter A with exact decode timing: pulse lands 36 cycles after release
      vbase = vcnt;
      press(10);
      tick(10);
      press(30);
      tick(35);
      chk("a_early_valid", 40'(o_valid), 40'h0);
      tick(1);
      chk("a_valid", 40'(o_valid), 40'h1);
      chk("a_char_same_cycle", 40'(o_char), 40'h41);
      chk("a_count_same_cycle", 40'(o_count), 40'h1);
      tick(4);
      chk("a_pulses", 40'(vcnt), 40'(vbase + 1));
      chk("a_buf0", 40'(o_buf[7:0]), 40'h41);
      chk("a_count", 40'(o_count), 40'h1);
      do_clear();
      chk("clr_buf", o_buf, SPACES);
      chk("clr_count", 40'(o_count), 40'h0);
      // fill then scroll
      repeat (5) send(".");
      chk("fill_buf", o_buf, {5{8'h45}});
      chk("fill_count", 40'(o_count), 40'h5);
      send("-");
      chk("scroll_buf", o_buf, {8'h54, 8'h45, 8'h45, 8'h45, 8'h45});
      chk("scroll_count", 40'(o_count), 40'h5);
      chk("scroll_char", 40'(o_char), 40'h54);
      send(".-");
      chk("scroll2_buf", o_buf, {8'h41, 8'h54, 8'h45, 8'h45, 8'h45});
      // dot/dash threshold and counter saturation on a long press
      do_clear();
      press(19);
      tick(40);
      chk("thr_dot", 40'(o_char), 40'h45);
      press(21);
      tick(40);
      chk("thr_dash", 40'(o_char), 40'h54);
      press(50);
      tick(40);
      chk("long_dash", 40'(o_char), 40'h54);
      chk("thr_buf", o_buf, {8'h20, 8'h20, 8'h54, 8'h54, 8'h45});
      chk("thr_count", 40'(o_count), 40'h3);
      // overflow, flag clearing, undefined code, digits
      send("......");
      chk("overflow", 40'(o_char), 40'h3F);
      send(".....");
      chk("digit5", 40'(o_char), 40'h35);
      send("..--");
      chk("undefined", 40'(o_char), 40'h3F);
      send("-----");
      chk("digit0", 40'(o_char), 40'h30);
      send("--..");
      chk("letter_z", 40'(o_char), 40'h5A);
      chk("mix_buf", o_buf, {8'h5A, 8'h30, 8'h3F, 8'h35, 8'h3F});
      chk("mix_count", 40'(o_count), 40'h5);
      // clear sampled on the very cycle the gap would decode
      vbase = vcnt;
      press(10);
      tick(35);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      chk("coll_valid", 40'(o_valid), 40'h0);
      tick(10);
      chk("coll_pulses", 40'(vcnt), 40'(vbase));
      chk("coll_count", 40'(o_count), 40'h0);
      chk("coll_buf", o_buf, SPACES);
      send("-");
      chk("post_clr_char", 40'(o_char), 40'h54);
      chk("post_clr_count", 40'(o_count), 40'h1);
      // reset mid-press, then a one-cycle glitch
      vbase = vcnt;
      key = 1'b1;
      tick(15);
      rst_n = 1'b0;
      tick(2);
      chk_reset_outputs("rst_mid");
      key = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      key = 1'b1;
      tick(1);
      key = 1'b0;
      tick(60);
      chk("glitch_pulses", 40'(vcnt), 40'(vbase));
      chk_reset_outputs("glitch");
      send("-");
      chk("post_rst_char", 40'(o_char), 40'h54);
      chk("post_rst_count", 40'(o_count), 40'h1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
